// File: rtl/bft_stream_endpoint_pkg.sv
// Shared packet layout, credit-packet field positions and sender FSM encoding
// for the BFT stream endpoint.
package bft_stream_endpoint_pkg;

    localparam int unsigned PKT_W           = 49;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned LEAF_W          = 4;
    localparam int unsigned PORT_W          = 4;

    localparam int unsigned VALID_BIT       = 48;
    localparam int unsigned DEST_LEAF_LSB   = 44;
    localparam int unsigned DEST_PORT_LSB   = 40;
    localparam int unsigned SRC_LEAF_LSB    = 36;
    localparam int unsigned SRC_PORT_LSB    = 32;
    localparam int unsigned PAYLOAD_LSB     = 0;

    localparam int unsigned CREDIT_PORT_LSB = 8;
    localparam int unsigned CREDIT_CNT_LSB  = 0;
    localparam int unsigned CREDIT_CNT_W    = 8;

    typedef enum logic {
        SEND_IDLE = 1'b0,
        SEND_BUSY = 1'b1
    } send_state_t;

    function automatic logic [PKT_W-1:0] make_pkt(
        input logic [LEAF_W-1:0] dest_leaf,
        input logic [PORT_W-1:0] dest_port,
        input logic [LEAF_W-1:0] src_leaf,
        input logic [PORT_W-1:0] src_port,
        input logic [DATA_W-1:0] payload
    );
        logic [PKT_W-1:0] p;
        p                               = '0;
        p[VALID_BIT]                    = 1'b1;
        p[DEST_LEAF_LSB +: LEAF_W]      = dest_leaf;
        p[DEST_PORT_LSB +: PORT_W]      = dest_port;
        p[SRC_LEAF_LSB  +: LEAF_W]      = src_leaf;
        p[SRC_PORT_LSB  +: PORT_W]      = src_port;
        p[PAYLOAD_LSB   +: DATA_W]      = payload;
        return p;
    endfunction

    function automatic logic [DATA_W-1:0] make_credit_payload(
        input logic [PORT_W-1:0]       port,
        input logic [CREDIT_CNT_W-1:0] count
    );
        logic [DATA_W-1:0] pl;
        pl                                  = '0;
        pl[CREDIT_PORT_LSB +: PORT_W]       = port;
        pl[CREDIT_CNT_LSB  +: CREDIT_CNT_W] = count;
        return pl;
    endfunction

endpackage

// File: rtl/bft_endpoint_fifo.sv
// RX FIFO for the BFT endpoint: first-word-fall-through, read and write in the
// same cycle allowed even when full; a write to a full FIFO without a read is dropped.
module bft_endpoint_fifo #(
    parameter int unsigned DATA_BITS  = 32,
    parameter int unsigned DEPTH_BITS = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data_c,
    output logic                 not_empty_c,
    output logic                 drop_c
);

    localparam int unsigned DEPTH = 1 << DEPTH_BITS;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [DEPTH_BITS:0]  wr_ptr;
    logic [DEPTH_BITS:0]  rd_ptr;
    logic                 empty;
    logic                 full;
    logic                 do_rd;
    logic                 do_wr;

    always_comb begin
        empty       = (wr_ptr == rd_ptr);
        full        = (wr_ptr[DEPTH_BITS] != rd_ptr[DEPTH_BITS]) &&
                      (wr_ptr[DEPTH_BITS-1:0] == rd_ptr[DEPTH_BITS-1:0]);
        do_rd       = rd_en && !empty;
        do_wr       = wr_en && (!full || do_rd);
        drop_c      = wr_en && full && !do_rd;
        not_empty_c = !empty;
        rd_data_c   = empty ? '0 : mem[rd_ptr[DEPTH_BITS-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (DEPTH_BITS+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (DEPTH_BITS+1)'(1);
        end
    end

    // Storage needs no reset: pointers define validity.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[DEPTH_BITS-1:0]] <= wr_data;
    end

endmodule

// File: rtl/bft_stream_endpoint.sv
// Credit-flow-controlled stream endpoint on a BFT leaf: TX words become packets
// to the peer, RX packets to this leaf/port land in a FIFO; freed RX space is
// returned to the peer as credit packets. Define BFT_STREAM_ENDPOINT_STATS_EN
// to add tx_count/drop_count outputs.
module bft_stream_endpoint
    import bft_stream_endpoint_pkg::*;
#(
    parameter int unsigned PACKET_BITS           = 49,
    parameter int unsigned PAYLOAD_BITS          = 32,
    parameter int unsigned NUM_LEAF_BITS         = 4,
    parameter int unsigned NUM_PORT_BITS         = 4,
    parameter int unsigned SELF_LEAF             = 0,
    parameter int unsigned SELF_PORT             = 2,
    parameter int unsigned PEER_LEAF             = 1,
    parameter int unsigned PEER_PORT             = 2,
    parameter int unsigned RX_DEPTH_BITS         = 7,
    parameter int unsigned INIT_CREDITS          = 128,
    parameter int unsigned FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PACKET_BITS-1:0]  din_bft2endpoint,
    output logic [PACKET_BITS-1:0]  dout_endpoint2bft,
    input  logic                    resend,
    input  logic [PAYLOAD_BITS-1:0] din_user2endpoint,
    input  logic                    vld_user2endpoint,
    output logic                    ack_endpoint2user,
    output logic [PAYLOAD_BITS-1:0] dout_endpoint2user,
    output logic                    vld_endpoint2user,
    input  logic                    ack_user2endpoint
`ifdef BFT_STREAM_ENDPOINT_STATS_EN
    ,
    output logic [31:0]             tx_count,
    output logic [31:0]             drop_count
`endif
);

    localparam int unsigned CRED_W = $clog2(INIT_CREDITS + 1);
    localparam int unsigned CONS_W = $clog2(FREESPACE_UPDATE_SIZE + 1);
    localparam int unsigned SUM_W  = ((CRED_W > CREDIT_CNT_W) ? CRED_W : CREDIT_CNT_W) + 1;

    send_state_t              send_state;
    logic [CRED_W-1:0]        credits;
    logic [CONS_W-1:0]        consumed;
    logic                     credit_pending;

    logic                     rx_valid;
    logic [NUM_LEAF_BITS-1:0] rx_dest_leaf;
    logic [NUM_PORT_BITS-1:0] rx_dest_port;
    logic [NUM_PORT_BITS-1:0] rx_credit_port;
    logic [CREDIT_CNT_W-1:0]  rx_credit_cnt;
    logic                     rx_to_self;
    logic                     rx_credit;
    logic                     rx_wr;
    logic                     rx_rd;
    logic                     credit_load;
    logic                     tx_load;
    logic [SUM_W-1:0]         cred_sum;
    logic [CRED_W-1:0]        cred_next;
    logic [CONS_W:0]          cons_next;
    logic                     cons_hit;
    logic [PACKET_BITS-1:0]   credit_pkt;
    logic [PACKET_BITS-1:0]   data_pkt;
    logic                     fifo_drop_c;
    logic                     src_unused;

    // Packet decode, flow-control handshakes and next credit/consumed values.
    always_comb begin
        rx_valid          = din_bft2endpoint[VALID_BIT];
        rx_dest_leaf      = din_bft2endpoint[DEST_LEAF_LSB +: NUM_LEAF_BITS];
        rx_dest_port      = din_bft2endpoint[DEST_PORT_LSB +: NUM_PORT_BITS];
        rx_credit_port    = din_bft2endpoint[CREDIT_PORT_LSB +: NUM_PORT_BITS];
        rx_credit_cnt     = din_bft2endpoint[CREDIT_CNT_LSB +: CREDIT_CNT_W];
        rx_to_self        = rx_valid && (rx_dest_leaf == NUM_LEAF_BITS'(SELF_LEAF));
        rx_credit         = rx_to_self && (rx_dest_port == '0) &&
                            (rx_credit_port == NUM_PORT_BITS'(SELF_PORT));
        rx_wr             = rx_to_self && (rx_dest_port != '0) &&
                            (rx_dest_port == NUM_PORT_BITS'(SELF_PORT));
        rx_rd             = vld_endpoint2user && ack_user2endpoint;

        ack_endpoint2user = !reset && vld_user2endpoint && (credits != '0) &&
                            !resend && !credit_pending;
        credit_load       = credit_pending && !resend;
        tx_load           = credit_load || ack_endpoint2user;

        cred_sum          = SUM_W'(credits) + (rx_credit ? SUM_W'(rx_credit_cnt) : '0) -
                            SUM_W'(ack_endpoint2user);
        cred_next         = (cred_sum > SUM_W'(INIT_CREDITS)) ? CRED_W'(INIT_CREDITS)
                                                              : CRED_W'(cred_sum);
        cons_next         = (CONS_W+1)'(consumed) + (CONS_W+1)'(rx_rd);
        cons_hit          = (cons_next >= (CONS_W+1)'(FREESPACE_UPDATE_SIZE));

        credit_pkt        = make_pkt(LEAF_W'(PEER_LEAF), '0, LEAF_W'(SELF_LEAF),
                                     PORT_W'(SELF_PORT),
                                     make_credit_payload(PORT_W'(SELF_PORT),
                                                         CREDIT_CNT_W'(FREESPACE_UPDATE_SIZE)));
        data_pkt          = make_pkt(LEAF_W'(PEER_LEAF), PORT_W'(PEER_PORT), LEAF_W'(SELF_LEAF),
                                     PORT_W'(SELF_PORT), din_user2endpoint);
        src_unused        = ^{din_bft2endpoint[SRC_PORT_LSB +: NUM_LEAF_BITS + NUM_PORT_BITS],
                              fifo_drop_c};
    end

    // Sender FSM, output packet register, credit and freed-space accounting.
    always_ff @(posedge clk) begin
        if (reset) begin
            send_state        <= SEND_IDLE;
            dout_endpoint2bft <= '0;
            credits           <= CRED_W'(INIT_CREDITS);
            consumed          <= '0;
            credit_pending    <= 1'b0;
        end else begin
            credits  <= cred_next;
            consumed <= cons_hit ? CONS_W'(cons_next - (CONS_W+1)'(FREESPACE_UPDATE_SIZE))
                                 : CONS_W'(cons_next);
            if (cons_hit)
                credit_pending <= 1'b1;
            else if (credit_load)
                credit_pending <= 1'b0;

            // A rejected packet stays on the bus until the BFT takes it.
            if (resend && (send_state == SEND_BUSY))
                dout_endpoint2bft <= dout_endpoint2bft;
            else if (credit_load)
                dout_endpoint2bft <= credit_pkt;
            else if (ack_endpoint2user)
                dout_endpoint2bft <= data_pkt;
            else
                dout_endpoint2bft <= '0;

            case (send_state)
                SEND_IDLE: if (tx_load) send_state <= SEND_BUSY;
                SEND_BUSY: if (!resend && !tx_load) send_state <= SEND_IDLE;
                default:   send_state <= SEND_IDLE;
            endcase
        end
    end

    bft_endpoint_fifo #(
        .DATA_BITS  (PAYLOAD_BITS),
        .DEPTH_BITS (RX_DEPTH_BITS)
    ) u_rx_fifo (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (rx_wr),
        .wr_data     (din_bft2endpoint[PAYLOAD_LSB +: PAYLOAD_BITS]),
        .rd_en       (ack_user2endpoint),
        .rd_data_c   (dout_endpoint2user),
        .not_empty_c (vld_endpoint2user),
        .drop_c      (fifo_drop_c)
    );

`ifdef BFT_STREAM_ENDPOINT_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_count   <= '0;
            drop_count <= '0;
        end else begin
            if (ack_endpoint2user) tx_count   <= tx_count + 32'd1;
            if (fifo_drop_c)       drop_count <= drop_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bft_stream_endpoint.sv
// Directed bench for bft_stream_endpoint: a vector table for single-cycle
// behaviour plus sequences for credits, resend, credit return and FIFO overflow.
module tb_bft_stream_endpoint;

    logic        clk = 1'b0;
    logic        reset;
    logic [48:0] din_bft2endpoint;
    logic [48:0] dout_endpoint2bft;
    logic        resend;
    logic [31:0] din_user2endpoint;
    logic        vld_user2endpoint;
    logic        ack_endpoint2user;
    logic [31:0] dout_endpoint2user;
    logic        vld_endpoint2user;
    logic        ack_user2endpoint;
`ifdef BFT_STREAM_ENDPOINT_STATS_EN
    logic [31:0] tx_count;
    logic [31:0] drop_count;
`endif

    int checks   = 0;
    int failures = 0;

    bft_stream_endpoint dut (
        .clk                (clk),
        .reset              (reset),
        .din_bft2endpoint   (din_bft2endpoint),
        .dout_endpoint2bft  (dout_endpoint2bft),
        .resend             (resend),
        .din_user2endpoint  (din_user2endpoint),
        .vld_user2endpoint  (vld_user2endpoint),
        .ack_endpoint2user  (ack_endpoint2user),
        .dout_endpoint2user (dout_endpoint2user),
        .vld_endpoint2user  (vld_endpoint2user),
        .ack_user2endpoint  (ack_user2endpoint)
`ifdef BFT_STREAM_ENDPOINT_STATS_EN
        ,
        .tx_count           (tx_count),
        .drop_count         (drop_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [48:0] bft_in;
        logic        tx_vld;
        logic [31:0] tx_data;
        logic        rs;
        logic        rx_ack;
        logic        exp_ack;
        logic [48:0] exp_dout;
        logic        exp_rx_vld;
        logic [31:0] exp_rx_data;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [48:0] pkt(input logic [3:0] dl, input logic [3:0] dp,
                                        input logic [3:0] sl, input logic [3:0] sp,
                                        input logic [31:0] pl);
        return {1'b1, dl, dp, sl, sp, pl};
    endfunction

    task automatic do_reset();
        reset             = 1'b1;
        din_bft2endpoint  = '0;
        resend            = 1'b0;
        din_user2endpoint = '0;
        vld_user2endpoint = 1'b0;
        ack_user2endpoint = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        int          next;
        int          tx_next;
        int          credit_seen;
        int          data_seen;
        int          data_bad;
        int          ack_gaps;
        logic [48:0] held;
        logic [31:0] got [$];
        logic [31:0] exp_word;

        //        rst   bft_in               vld   data           rs    rxack  ack   dout                    rxv   rxdata
        vecs[0]  = '{1'b1, '0,                  1'b1, '0,            1'b0, 1'b0, 1'b0, '0,                     1'b0, '0};
        vecs[1]  = '{1'b0, '0,                  1'b1, 32'hDEADBEEF,  1'b0, 1'b0, 1'b1, 49'h1_1202_DEADBEEF,    1'b0, '0};
        vecs[2]  = '{1'b0, '0,                  1'b0, '0,            1'b0, 1'b0, 1'b0, '0,                     1'b0, '0};
        vecs[3]  = '{1'b0, 49'h1_0212_11111111, 1'b0, '0,            1'b0, 1'b0, 1'b0, '0,                     1'b1, 32'h11111111};
        vecs[4]  = '{1'b0, 49'h1_1212_22222222, 1'b0, '0,            1'b0, 1'b1, 1'b0, '0,                     1'b0, '0};
        vecs[5]  = '{1'b0, 49'h1_0312_33333333, 1'b0, '0,            1'b0, 1'b0, 1'b0, '0,                     1'b0, '0};
        vecs[6]  = '{1'b0, 49'h0_0212_44444444, 1'b0, '0,            1'b0, 1'b0, 1'b0, '0,                     1'b0, '0};
        vecs[7]  = '{1'b0, '0,                  1'b1, 32'hA5A5A5A5,  1'b1, 1'b0, 1'b0, '0,                     1'b0, '0};
        vecs[8]  = '{1'b0, '0,                  1'b1, 32'h12345678,  1'b0, 1'b0, 1'b1, 49'h1_1202_12345678,    1'b0, '0};
        vecs[9]  = '{1'b0, '0,                  1'b1, 32'h00000009,  1'b1, 1'b0, 1'b0, 49'h1_1202_12345678,    1'b0, '0};
        vecs[10] = '{1'b0, '0,                  1'b1, 32'h00000009,  1'b0, 1'b0, 1'b1, 49'h1_1202_00000009,    1'b0, '0};
        vecs[11] = '{1'b0, '0,                  1'b0, '0,            1'b0, 1'b0, 1'b0, '0,                     1'b0, '0};

        for (int i = 0; i < 12; i++) begin
            reset             = vecs[i].rst;
            din_bft2endpoint  = vecs[i].bft_in;
            vld_user2endpoint = vecs[i].tx_vld;
            din_user2endpoint = vecs[i].tx_data;
            resend            = vecs[i].rs;
            ack_user2endpoint = vecs[i].rx_ack;
            #1;
            check($sformatf("vec%0d_ack", i), 64'(ack_endpoint2user), 64'(vecs[i].exp_ack));
            tick();
            check($sformatf("vec%0d_dout", i), 64'(dout_endpoint2bft), 64'(vecs[i].exp_dout));
            check($sformatf("vec%0d_rx_vld", i), 64'(vld_endpoint2user), 64'(vecs[i].exp_rx_vld));
            check($sformatf("vec%0d_rx_data", i), 64'(dout_endpoint2user), 64'(vecs[i].exp_rx_data));
        end

        // Reset in the middle of a resend with the RX FIFO half full.
        do_reset();
        for (int i = 0; i < 64; i++) begin
            din_bft2endpoint = pkt(4'h0, 4'h2, 4'h1, 4'h2, 32'h5000 + 32'(i));
            tick();
        end
        din_bft2endpoint  = '0;
        vld_user2endpoint = 1'b1;
        din_user2endpoint = 32'hCAFE0001;
        #1;
        check("mid_send_ack", 64'(ack_endpoint2user), 64'd1);
        tick();
        vld_user2endpoint = 1'b0;
        resend            = 1'b1;
        held              = dout_endpoint2bft;
        check("mid_send_dout", 64'(held), 64'(pkt(4'h1, 4'h2, 4'h0, 4'h2, 32'hCAFE0001)));
        tick();
        check("mid_resend_hold", 64'(dout_endpoint2bft), 64'(held));
        check("half_full_vld", 64'(vld_endpoint2user), 64'd1);
        reset             = 1'b1;
        vld_user2endpoint = 1'b1;
        #1;
        check("ack_in_reset", 64'(ack_endpoint2user), 64'd0);
        tick();
        check("reset_dout", 64'(dout_endpoint2bft), 64'd0);
        check("reset_rx_vld", 64'(vld_endpoint2user), 64'd0);
        check("reset_rx_data", 64'(dout_endpoint2user), 64'd0);
        reset  = 1'b0;
        resend = 1'b0;

        // Credits restored to 128 by the reset: exactly 128 words accepted.
        n = 0;
        for (int c = 0; c < 128; c++) begin
            din_user2endpoint = 32'(c);
            #1;
            if (ack_endpoint2user) n++;
            tick();
        end
        check("init_credit_acks", 64'(n), 64'd128);
        check("last_tx_dout", 64'(dout_endpoint2bft), 64'(pkt(4'h1, 4'h2, 4'h0, 4'h2, 32'd127)));
        #1;
        check("credit_exhausted", 64'(ack_endpoint2user), 64'd0);
        din_bft2endpoint = pkt(4'h0, 4'h0, 4'h1, 4'h2, 32'h308);
        tick();
        din_bft2endpoint = '0;
        check("foreign_credit_ack", 64'(ack_endpoint2user), 64'd0);
        check("credit_not_in_fifo", 64'(vld_endpoint2user), 64'd0);
        din_bft2endpoint = pkt(4'h0, 4'h0, 4'h1, 4'h2, 32'h208);
        tick();
        din_bft2endpoint = '0;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (ack_endpoint2user) n++;
            tick();
        end
        check("credit_return_acks", 64'(n), 64'd8);

        // Credit counter saturates at 128 when extra credit arrives.
        do_reset();
        din_bft2endpoint = pkt(4'h0, 4'h0, 4'h1, 4'h2, 32'h2FF);
        tick();
        din_bft2endpoint  = '0;
        vld_user2endpoint = 1'b1;
        n = 0;
        for (int c = 0; c < 140; c++) begin
            #1;
            if (ack_endpoint2user) n++;
            tick();
        end
        check("saturated_acks", 64'(n), 64'd128);

        // Three resend cycles: output held, nothing lost or duplicated.
        do_reset();
        next = 0;
        got.delete();
        for (int c = 0; c < 12; c++) begin
            resend            = (c >= 2 && c <= 4);
            vld_user2endpoint = (next < 5);
            din_user2endpoint = 32'h7000 + 32'(next);
            #1;
            if (c == 2) held = dout_endpoint2bft;
            if (c >= 3 && c <= 5)
                check($sformatf("resend_hold_c%0d", c), 64'(dout_endpoint2bft), 64'(held));
            if (dout_endpoint2bft[48] && !resend) got.push_back(dout_endpoint2bft[31:0]);
            if (ack_endpoint2user) next++;
            tick();
        end
        resend = 1'b0;
        check("resend_delivered", 64'(got.size()), 64'd5);
        for (int i = 0; i < got.size(); i++)
            check($sformatf("resend_word%0d", i), 64'(got[i]), 64'h7000 + 64'(i));

        // 64 consumed RX words produce one credit packet ahead of pending TX data.
        do_reset();
        ack_user2endpoint = 1'b1;
        tx_next = 0; credit_seen = 0; data_seen = 0; data_bad = 0; ack_gaps = 0;
        for (int c = 0; c < 90; c++) begin
            din_bft2endpoint  = (c < 64) ? pkt(4'h0, 4'h2, 4'h1, 4'h2, 32'(c)) : '0;
            vld_user2endpoint = (c < 85);
            din_user2endpoint = 32'hB000 + 32'(tx_next);
            #1;
            if (dout_endpoint2bft[48]) begin
                if (dout_endpoint2bft[43:40] == 4'h0) begin
                    credit_seen++;
                    check("credit_pkt", 64'(dout_endpoint2bft), 64'h1_1002_00000240);
                end else begin
                    if (dout_endpoint2bft[31:0] != 32'hB000 + 32'(data_seen)) data_bad++;
                    data_seen++;
                end
            end
            if (vld_user2endpoint && !ack_endpoint2user) ack_gaps++;
            if (ack_endpoint2user) tx_next++;
            tick();
        end
        check("credit_pkt_count", 64'(credit_seen), 64'd1);
        check("credit_ack_gaps", 64'(ack_gaps), 64'd1);
        check("tx_data_order_errors", 64'(data_bad), 64'd0);
        check("tx_data_count", 64'(data_seen), 64'(tx_next));

        // Overflow: 129 writes with no reads, then read+write while full.
        do_reset();
        for (int i = 0; i < 129; i++) begin
            din_bft2endpoint = pkt(4'h0, 4'h2, 4'h1, 4'h2, 32'hC000 + 32'(i));
            tick();
        end
        din_bft2endpoint  = pkt(4'h0, 4'h2, 4'h1, 4'h2, 32'hC999);
        ack_user2endpoint = 1'b1;
        #1;
        check("full_rx_vld", 64'(vld_endpoint2user), 64'd1);
        check("full_head", 64'(dout_endpoint2user), 64'hC000);
`ifdef BFT_STREAM_ENDPOINT_STATS_EN
        check("drop_count", 64'(drop_count), 64'd1);
`endif
        tick();
        din_bft2endpoint = '0;
        data_bad = 0;
        for (int i = 1; i <= 128; i++) begin
            exp_word = (i < 128) ? 32'hC000 + 32'(i) : 32'hC999;
            if (dout_endpoint2user !== exp_word || !vld_endpoint2user) begin
                if (data_bad == 0)
                    $display("FAIL rx_order word%0d actual=%0h required=%0h", i, dout_endpoint2user, exp_word);
                data_bad++;
            end
            tick();
        end
        checks++;
        if (data_bad != 0) failures++;
        check("drained_rx_vld", 64'(vld_endpoint2user), 64'd0);
`ifdef BFT_STREAM_ENDPOINT_STATS_EN
        check("tx_count_zero", 64'(tx_count), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bft_stream_endpoint.md
BFT_STREAM_ENDPOINT -- requirements
Module: bft_stream_endpoint

Interface
REQ-001 The block SHALL have these parameters:
- PACKET_BITS, 49, BFT packet width.
- PAYLOAD_BITS, 32, data width.
- NUM_LEAF_BITS, 4, leaf address width.
- NUM_PORT_BITS, 4, port address width.
- SELF_LEAF, 0, own leaf.
- SELF_PORT, 2, own receive port.
- PEER_LEAF, 1, destination leaf.
- PEER_PORT, 2, destination port.
- RX_DEPTH_BITS, 7, log2 of RX FIFO depth.
- INIT_CREDITS, 128, peer buffer words.
- FREESPACE_UPDATE_SIZE, 64, words consumed per credit return.
REQ-002 The block SHALL have these ports, clock and reset first:
- clk  in  1  sole clock.
- reset  in  1  synchronous active-high reset.
- din_bft2endpoint  in  49  packet from BFT.
- dout_endpoint2bft  out  49  packet to BFT.
- resend  in  1  BFT rejected the packet on dout.
- din_user2endpoint  in  32  TX data.
- vld_user2endpoint  in  1  TX valid.
- ack_endpoint2user  out  1  TX accept.
- dout_endpoint2user  out  32  RX data.
- vld_endpoint2user  out  1  RX valid.
- ack_user2endpoint  in  1  RX accept.
REQ-003 Packet layout, MSB to LSB, SHALL be: valid[48], dest_leaf[47:44], dest_port[43:40], src_leaf[39:36], src_port[35:32], payload[31:0].
REQ-004 A user transfer SHALL occur only in a cycle where vld and ack are both high.

Function
REQ-005 A credit packet SHALL have dest_port==0, payload[11:8]=credited port and payload[7:0]=credit count; all other valid packets with dest_port!=0 SHALL be data packets.
REQ-006 ack_endpoint2user SHALL be combinational: vld_user2endpoint && credits>0 && !resend && no credit packet pending.
REQ-007 An accepted TX word SHALL appear on dout_endpoint2bft the next cycle (1-cycle latency), addressed PEER_LEAF/PEER_PORT with source SELF_LEAF/SELF_PORT.
REQ-008 While resend is high, dout_endpoint2bft SHALL hold its current value, and no new packet SHALL be loaded.
REQ-009 With no packet to send and resend low, dout_endpoint2bft SHALL be all zero (valid=0).
REQ-010 The output SHALL use a two-state FSM:
- SEND_IDLE -> SEND_BUSY when a packet is loaded.
- SEND_BUSY -> SEND_IDLE when resend is low and nothing new is loaded.
- SEND_BUSY -> SEND_BUSY on resend or a back-to-back load.
REQ-011 The credit counter SHALL decrement on each TX acceptance.
REQ-012 The credit counter SHALL add the count from each received credit packet whose dest_leaf==SELF_LEAF and credited port==SELF_PORT.
REQ-013 A simultaneous decrement and increment SHALL apply the net value.
REQ-014 The credit counter SHALL saturate at INIT_CREDITS.
REQ-015 Received data packets with valid=1, dest_leaf==SELF_LEAF and dest_port==SELF_PORT SHALL be written to the RX FIFO (depth 2^RX_DEPTH_BITS); all other packets SHALL be ignored.
REQ-016 The RX FIFO SHALL support simultaneous write and read, including when full.
REQ-017 A write to a full FIFO with no simultaneous read SHALL be dropped.
REQ-018 vld_endpoint2user SHALL equal FIFO not-empty, and dout_endpoint2user SHALL be the FIFO head.
REQ-019 A consumed-word counter SHALL increment on each RX user transfer.
REQ-020 When the consumed-word counter reaches FREESPACE_UPDATE_SIZE, it SHALL subtract FREESPACE_UPDATE_SIZE and set credit-pending.
REQ-021 A pending credit packet SHALL take priority over TX data at the next free output slot, carrying dest PEER_LEAF/port 0 and payload {credited port=SELF_PORT, count=FREESPACE_UPDATE_SIZE}.
REQ-022 Loading the credit packet SHALL clear credit-pending.

Reset
REQ-023 On a clk edge with reset high, the block SHALL set:
- dout_endpoint2bft=0.
- FSM=SEND_IDLE.
- credits=INIT_CREDITS.
- RX FIFO empty (vld_endpoint2user=0, dout_endpoint2user=0).
- Consumed-word counter=0, credit-pending=0.
REQ-024 A packet held for resend SHALL be discarded by reset.
REQ-025 ack_endpoint2user SHALL be 0 while reset is high.

Configuration
REQ-026 With BFT_STREAM_ENDPOINT_STATS_EN defined, the block SHALL add outputs tx_count[31:0] (TX acceptances) and drop_count[31:0] (RX overflow drops), both wrapping and reset to 0.
REQ-027 Without BFT_STREAM_ENDPOINT_STATS_EN, those ports and counters SHALL be absent.

Structure
REQ-028 A shared package SHALL hold the packet field offsets/widths, the credit-packet field positions and the FSM state encoding.
REQ-029 The RX FIFO SHALL be a sub-module named bft_endpoint_fifo.

Verification
REQ-030 Word 0xDEADBEEF with vld held high -> ack the same cycle; next cycle dout={1,4'h1,4'h2,4'h0,4'h2,32'hDEADBEEF}.
REQ-031 128 TX words with no credit return -> the 129th is not acked; inject credit packet count 8 -> exactly 8 more accepted.
REQ-032 resend high for 3 cycles after a send -> dout unchanged for those cycles, then next packet issues; no word lost or duplicated.
REQ-033 64 RX words to SELF_LEAF/SELF_PORT consumed while user TX is also active -> one credit packet {dest leaf 1, port 0, payload 12'h240} issued before pending TX data.
REQ-034 129 RX words with ack_user2endpoint low -> FIFO holds first 128, last dropped (drop_count=1 with STATS_EN).
REQ-035 Reset asserted mid-resend with FIFO half full -> next cycle dout=0, vld_endpoint2user=0, credits=128.
